// File: rtl/octal_ram_init_seq.sv
// Octal PSRAM power-up sequencer. It waits out the power-up time, then issues the table's mode-register writes and reads.
// Define OCTAL_RAM_RDBACK_CHK_EN to build the write shadow and the readback compare.
module octal_ram_init_seq #(
    parameter int unsigned PWRUP_CYCLES   = 20000,
    parameter int unsigned WR_CNT         = 4,
    parameter int unsigned LAST_NO        = 9,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       iClk,
    input  logic       iRst_N,
    input  logic       iStart,
    output logic [7:0] oTblNo,
    input  logic [7:0] iTblAddr,
    input  logic [7:0] iTblData,
    output logic       oCmdReq,
    output logic       oCmdWr,
    output logic [7:0] oCmdAddr,
    output logic [7:0] oCmdData,
    input  logic       iCmdAck,
    input  logic       iRdValid,
    input  logic [7:0] iRdData,
    output logic       oRdStb,
    output logic [7:0] oRdAddr,
    output logic [7:0] oRdData,
    output logic       oBusy,
    output logic       oDone,
    output logic       oErr,
    output logic [7:0] oErrNo
);
    localparam int unsigned PW_W = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
    localparam int unsigned TO_W = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_PWRUP, S_LOAD, S_ISSUE, S_WAIT_RD, S_NEXT, S_DONE, S_ERR
    } state_e;

    state_e          state_q, state_d;
    logic [PW_W-1:0] pw_cnt_q, pw_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      tbl_no_q, tbl_no_d;
    logic            cmd_req_q, cmd_req_d;
    logic            cmd_wr_q, cmd_wr_d;
    logic [7:0]      cmd_addr_q, cmd_addr_d;
    logic [7:0]      cmd_data_q, cmd_data_d;
    logic            rd_stb_q, rd_stb_d;
    logic [7:0]      rd_addr_q, rd_addr_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      err_no_q, err_no_d;

    logic start_ok;
    logic to_expired;
    logic is_last;
    logic is_wr_idx;
    logic rd_mismatch;

    assign start_ok   = iStart && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign to_expired = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign is_last    = (tbl_no_q == 8'(LAST_NO));
    assign is_wr_idx  = (tbl_no_q < 8'(WR_CNT));

`ifdef OCTAL_RAM_RDBACK_CHK_EN
    // Write shadow: one slot each for MA 0x00, 0x04, 0x06, 0x08
    logic [3:0] sh_vld_q;
    logic [7:0] sh_data_q [4];
    logic       slot_hit;
    logic [1:0] slot;

    always_comb begin
        slot_hit = 1'b1;
        slot     = 2'd0;
        case (cmd_addr_q)
            8'h00:   slot = 2'd0;
            8'h04:   slot = 2'd1;
            8'h06:   slot = 2'd2;
            8'h08:   slot = 2'd3;
            default: slot_hit = 1'b0;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            sh_vld_q <= '0;
            for (int i = 0; i < 4; i++) sh_data_q[i] <= '0;
        end else if (start_ok) begin
            sh_vld_q <= '0;
        end else if (state_q == S_ISSUE && iCmdAck && cmd_wr_q && slot_hit) begin
            sh_vld_q[slot]  <= 1'b1;
            sh_data_q[slot] <= cmd_data_q;
        end
    end

    assign rd_mismatch = slot_hit && sh_vld_q[slot] && (sh_data_q[slot] != iRdData);
`else
    assign rd_mismatch = 1'b0;
`endif

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start_ok) state_d = S_PWRUP;
            S_PWRUP:   if (pw_cnt_q == '0) state_d = S_LOAD;
            S_LOAD:    state_d = S_ISSUE;
            S_ISSUE: begin
                if (iCmdAck)         state_d = cmd_wr_q ? S_NEXT : S_WAIT_RD;
                else if (to_expired) state_d = S_ERR;
            end
            S_WAIT_RD: begin
                if (iRdValid)        state_d = rd_mismatch ? S_ERR : S_NEXT;
                else if (to_expired) state_d = S_ERR;
            end
            S_NEXT:    state_d = is_last ? S_DONE : S_LOAD;
            default:   state_d = S_IDLE;
        endcase
    end

    // Next values of every registered output and counter
    always_comb begin
        tbl_no_d   = tbl_no_q;
        cmd_req_d  = cmd_req_q;
        cmd_wr_d   = cmd_wr_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        rd_stb_d   = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_data_d  = rd_data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        err_no_d   = err_no_q;
        pw_cnt_d   = pw_cnt_q;
        to_cnt_d   = to_cnt_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_ok) begin
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    err_no_d = 8'h00;
                    busy_d   = 1'b1;
                    tbl_no_d = 8'h00;
                    pw_cnt_d = PW_W'(PWRUP_CYCLES - 1);
                end
            end
            S_PWRUP: begin
                if (pw_cnt_q != '0) pw_cnt_d = pw_cnt_q - PW_W'(1);
            end
            S_LOAD: begin
                cmd_addr_d = iTblAddr;
                cmd_wr_d   = is_wr_idx;
                cmd_data_d = is_wr_idx ? iTblData : 8'h00;
                cmd_req_d  = 1'b1;
                to_cnt_d   = '0;
            end
            S_ISSUE: begin
                if (iCmdAck) begin
                    cmd_req_d = 1'b0;
                    to_cnt_d  = '0;
                end else if (to_expired) begin
                    cmd_req_d = 1'b0;
                    busy_d    = 1'b0;
                    err_d     = 1'b1;
                    err_no_d  = tbl_no_q;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_WAIT_RD: begin
                if (iRdValid) begin
                    rd_stb_d  = 1'b1;
                    rd_addr_d = cmd_addr_q;
                    rd_data_d = iRdData;
                    if (rd_mismatch) begin
                        busy_d   = 1'b0;
                        err_d    = 1'b1;
                        err_no_d = tbl_no_q;
                    end
                end else if (to_expired) begin
                    busy_d   = 1'b0;
                    err_d    = 1'b1;
                    err_no_d = tbl_no_q;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_NEXT: begin
                if (is_last) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    tbl_no_d = tbl_no_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            tbl_no_q   <= '0;
            cmd_req_q  <= 1'b0;
            cmd_wr_q   <= 1'b0;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
            rd_stb_q   <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_no_q   <= '0;
            pw_cnt_q   <= '0;
            to_cnt_q   <= '0;
        end else begin
            tbl_no_q   <= tbl_no_d;
            cmd_req_q  <= cmd_req_d;
            cmd_wr_q   <= cmd_wr_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
            rd_stb_q   <= rd_stb_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_no_q   <= err_no_d;
            pw_cnt_q   <= pw_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign oTblNo   = tbl_no_q;
    assign oCmdReq  = cmd_req_q;
    assign oCmdWr   = cmd_wr_q;
    assign oCmdAddr = cmd_addr_q;
    assign oCmdData = cmd_data_q;
    assign oRdStb   = rd_stb_q;
    assign oRdAddr  = rd_addr_q;
    assign oRdData  = rd_data_q;
    assign oBusy    = busy_q;
    assign oDone    = done_q;
    assign oErr     = err_q;
    assign oErrNo   = err_no_q;

endmodule

// File: tb/tb_octal_ram_init_seq.sv
// Bench for octal_ram_init_seq: a PHY model with echoing mode registers, a table-level reference model and scenario tasks.
`timescale 1ns/1ps
module tb_octal_ram_init_seq;
    localparam int unsigned P = 10;
    localparam int LAST = 9;
    localparam int WRN  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iStart;
    logic [7:0] oTblNo, iTblAddr, iTblData;
    logic       oCmdReq, oCmdWr;
    logic [7:0] oCmdAddr, oCmdData;
    logic       iCmdAck, iRdValid;
    logic [7:0] iRdData;
    logic       oRdStb;
    logic [7:0] oRdAddr, oRdData;
    logic       oBusy, oDone, oErr;
    logic [7:0] oErrNo;

    octal_ram_init_seq #(.PWRUP_CYCLES(P), .WR_CNT(4), .LAST_NO(9), .TIMEOUT_CYCLES(255)) dut (
        .iClk(clk), .iRst_N(rst_n), .iStart(iStart), .oTblNo(oTblNo),
        .iTblAddr(iTblAddr), .iTblData(iTblData), .oCmdReq(oCmdReq), .oCmdWr(oCmdWr),
        .oCmdAddr(oCmdAddr), .oCmdData(oCmdData), .iCmdAck(iCmdAck), .iRdValid(iRdValid),
        .iRdData(iRdData), .oRdStb(oRdStb), .oRdAddr(oRdAddr), .oRdData(oRdData),
        .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oErrNo(oErrNo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] tbl_addr [10];
    logic [7:0] tbl_data [10];
    logic [7:0] id_val [4];

    always_comb begin
        iTblAddr = 8'h00;
        iTblData = 8'h00;
        if (oTblNo < 8'd10) begin
            iTblAddr = tbl_addr[oTblNo[3:0]];
            iTblData = tbl_data[oTblNo[3:0]];
        end
    end

    // PHY model controls
    int         ack_delay_fix;
    bit         ack_rand;
    bit         stray_en;
    int         drop_idx;
    int         corrupt_idx;
    logic [7:0] corrupt_xor;
    int         busy_start_at;

    int          req_age, cur_delay, rd_wait, instab, last_ack_cyc;
    bit          rd_pend;
    logic [7:0]  rd_pend_val, v_phy;
    logic [16:0] lat;
    logic [7:0]  mr [256];
    logic [16:0] cmd_q [$];

    // PHY: acks after a delay, echoes written MRs, returns fixed ID bytes for MA 1..3
    always @(negedge clk) begin
        iCmdAck  = 1'b0;
        iRdValid = 1'b0;
        iRdData  = 8'h00;
        if (!rst_n) begin
            req_age = 0;
            rd_pend = 1'b0;
        end else begin
            if (rd_pend) begin
                if (rd_wait == 0) begin
                    iRdValid = 1'b1;
                    iRdData  = rd_pend_val;
                    rd_pend  = 1'b0;
                end else rd_wait--;
            end
            if (oCmdReq) begin
                if (req_age == 0) begin
                    lat = {oCmdWr, oCmdAddr, oCmdData};
                    cur_delay = ack_rand ? int'($urandom_range(0, 3)) : ack_delay_fix;
                end else if ({oCmdWr, oCmdAddr, oCmdData} !== lat) instab++;
                if (req_age == cur_delay) begin
                    iCmdAck = 1'b1;
                    req_age = 0;
                    cmd_q.push_back({oCmdWr, oCmdAddr, oCmdData});
                    last_ack_cyc = cyc;
                    if (oCmdWr) mr[oCmdAddr] = oCmdData;
                    else if (int'(oTblNo) != drop_idx) begin
                        v_phy = (oCmdAddr >= 8'h01 && oCmdAddr <= 8'h03) ? id_val[oCmdAddr[1:0]] : mr[oCmdAddr];
                        if (int'(oTblNo) == corrupt_idx) v_phy = v_phy ^ corrupt_xor;
                        rd_pend_val = v_phy;
                        rd_wait = ack_rand ? int'($urandom_range(0, 3)) : 0;
                        rd_pend = 1'b1;
                    end
                end else begin
                    req_age++;
                    if (stray_en) begin
                        iRdValid = 1'b1;
                        iRdData  = 8'hEE;
                    end
                end
            end else req_age = 0;
        end
    end

    // Observation of readback strobes and request pulses
    logic [15:0] rd_q [$];
    int          rise_q [$];
    int          len_q [$];
    bit          req_prev = 1'b0;
    int          last_rise = 0;
    always @(negedge clk) begin
        if (oRdStb) rd_q.push_back({oRdAddr, oRdData});
        if (oCmdReq && !req_prev) begin
            rise_q.push_back(cyc);
            last_rise = cyc;
        end
        if (!oCmdReq && req_prev) len_q.push_back(cyc - last_rise);
        req_prev = oCmdReq;
    end

    // Reference model: walks the table as the datasheet describes the sequence
    logic [16:0] exp_cmd_q [$];
    logic [15:0] exp_rd_q [$];
    bit          exp_done, exp_err;
    int          exp_errno;

    task automatic build_model();
        logic [7:0] mem [256];
        bit         wrote [256];
        logic [7:0] v;
        logic [7:0] a;
        exp_cmd_q.delete();
        exp_rd_q.delete();
        exp_done = 1'b0;
        exp_err = 1'b0;
        exp_errno = 0;
        for (int j = 0; j < 256; j++) begin
            wrote[j] = 1'b0;
            mem[j] = 8'h00;
        end
        for (int i = 0; i <= LAST; i++) begin
            a = tbl_addr[i];
            if (i < WRN) begin
                exp_cmd_q.push_back({1'b1, a, tbl_data[i]});
                mem[a] = tbl_data[i];
                wrote[a] = 1'b1;
            end else begin
                exp_cmd_q.push_back({1'b0, a, 8'h00});
                if (i == drop_idx) begin
                    exp_err = 1'b1;
                    exp_errno = i;
                    return;
                end
                v = (a >= 8'h01 && a <= 8'h03) ? id_val[a[1:0]] : mem[a];
                if (i == corrupt_idx) v = v ^ corrupt_xor;
                exp_rd_q.push_back({a, v});
`ifdef OCTAL_RAM_RDBACK_CHK_EN
                if (wrote[a] && v != mem[a]) begin
                    exp_err = 1'b1;
                    exp_errno = i;
                    return;
                end
`endif
            end
        end
        exp_done = 1'b1;
    endtask

    task automatic set_nominal_table();
        logic [7:0] na [10];
        logic [7:0] nd [10];
        na = '{8'h00, 8'h04, 8'h06, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h08};
        nd = '{8'h28, 8'h40, 8'hF0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 10; i++) begin
            tbl_addr[i] = na[i];
            tbl_data[i] = nd[i];
        end
        id_val[0] = 8'h00; id_val[1] = 8'h0D; id_val[2] = 8'h5A; id_val[3] = 8'h93;
    endtask

    task automatic set_phy(input int dly, input bit rnd, input bit stray, input int drop, input int cidx, input logic [7:0] cx);
        ack_delay_fix = dly; ack_rand = rnd; stray_en = stray;
        drop_idx = drop; corrupt_idx = cidx; corrupt_xor = cx; busy_start_at = -1;
    endtask

    // Pulses start and waits (bounded) for done or error
    task automatic run_seq(output int t_start, output int t_end, output bit busy1);
        int k;
        build_model();
        cmd_q.delete(); rd_q.delete(); rise_q.delete(); len_q.delete();
        instab = 0;
        @(negedge clk); iStart = 1'b1;
        @(negedge clk); iStart = 1'b0;
        t_start = cyc;
        busy1 = oBusy;
        k = 0;
        while (!(oDone || oErr) && k < 5000) begin
            @(negedge clk);
            k++;
            iStart = (k == busy_start_at);
        end
        iStart = 1'b0;
        t_end = cyc;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({oTblNo, oCmdReq, oCmdWr, oCmdAddr, oCmdData, oRdStb, oRdAddr, oRdData, oBusy, oDone, oErr, oErrNo} !== 54'd0) begin
            n_err++;
            $display("FAIL reset_values: got tbl=%h req=%b busy=%b done=%b err=%b errno=%h, all required 0", oTblNo, oCmdReq, oBusy, oDone, oErr, oErrNo);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nominal();
        int ts, te, gap;
        bit b1;
        set_nominal_table();
        set_phy(0, 1'b0, 1'b0, -1, -1, 8'h00);
        run_seq(ts, te, b1);
        n_vec++;
        if (b1 !== 1'b1) begin n_err++; $display("FAIL nominal busy_at_T+1: got %b required 1", b1); end
        n_vec++;
        if (rise_q.size() == 0 || rise_q[0] != ts + int'(P) + 1) begin
            n_err++;
            $display("FAIL nominal first_req_cycle: got %0d required %0d", (rise_q.size() > 0) ? rise_q[0] : -1, ts + int'(P) + 1);
        end
        for (int i = 1; i <= WRN && i < rise_q.size(); i++) begin
            gap = rise_q[i] - (rise_q[i-1] + len_q[i-1]);
            n_vec++;
            if (gap != 2) begin n_err++; $display("FAIL nominal idle_gap[%0d]: got %0d required 2", i, gap); end
        end
        n_vec++;
        if (cmd_q.size() != exp_cmd_q.size()) begin n_err++; $display("FAIL nominal cmd_count: got %0d required %0d", cmd_q.size(), exp_cmd_q.size()); end
        for (int i = 0; i < exp_cmd_q.size() && i < cmd_q.size(); i++) begin
            n_vec++;
            if (cmd_q[i] !== exp_cmd_q[i]) begin n_err++; $display("FAIL nominal cmd[%0d]: got %h required %h", i, cmd_q[i], exp_cmd_q[i]); end
        end
        n_vec++;
        if (rd_q.size() != exp_rd_q.size()) begin n_err++; $display("FAIL nominal rd_count: got %0d required %0d", rd_q.size(), exp_rd_q.size()); end
        for (int i = 0; i < exp_rd_q.size() && i < rd_q.size(); i++) begin
            n_vec++;
            if (rd_q[i] !== exp_rd_q[i]) begin n_err++; $display("FAIL nominal rd[%0d]: got %h required %h", i, rd_q[i], exp_rd_q[i]); end
        end
        n_vec++;
        if ({oDone, oErr, oBusy} !== 3'b100) begin n_err++; $display("FAIL nominal status: got done/err/busy=%b%b%b required 100", oDone, oErr, oBusy); end
    endtask

    task automatic test_ack_delay();
        int ts, te;
        bit b1;
        set_nominal_table();
        set_phy(5, 1'b0, 1'b1, -1, -1, 8'h00);
        busy_start_at = 30;
        run_seq(ts, te, b1);
        n_vec++;
        if (len_q.size() != LAST + 1) begin n_err++; $display("FAIL ack_delay req_count: got %0d required %0d", len_q.size(), LAST + 1); end
        foreach (len_q[i]) begin
            n_vec++;
            if (len_q[i] != 6) begin n_err++; $display("FAIL ack_delay req_len[%0d]: got %0d required 6", i, len_q[i]); end
        end
        n_vec++;
        if (instab != 0) begin n_err++; $display("FAIL ack_delay field_stability: got %0d changes required 0", instab); end
        n_vec++;
        if (cmd_q.size() != exp_cmd_q.size()) begin n_err++; $display("FAIL ack_delay cmd_count: got %0d required %0d", cmd_q.size(), exp_cmd_q.size()); end
        for (int i = 0; i < exp_cmd_q.size() && i < cmd_q.size(); i++) begin
            n_vec++;
            if (cmd_q[i] !== exp_cmd_q[i]) begin n_err++; $display("FAIL ack_delay cmd[%0d]: got %h required %h", i, cmd_q[i], exp_cmd_q[i]); end
        end
        n_vec++;
        if (rd_q.size() != exp_rd_q.size()) begin n_err++; $display("FAIL ack_delay rd_count: got %0d required %0d", rd_q.size(), exp_rd_q.size()); end
        n_vec++;
        if ({oDone, oErr} !== 2'b10) begin n_err++; $display("FAIL ack_delay status: got done/err=%b%b required 10", oDone, oErr); end
    endtask

    task automatic test_mismatch();
        int ts, te;
        bit b1;
        set_nominal_table();
        set_phy(0, 1'b0, 1'b0, -1, 4, 8'h08);
        run_seq(ts, te, b1);
        n_vec++;
        if ({oDone, oErr} !== {exp_done, exp_err}) begin
            n_err++;
            $display("FAIL mismatch status: got done/err=%b%b required %b%b", oDone, oErr, exp_done, exp_err);
        end
        n_vec++;
        if (oErrNo !== 8'(exp_errno)) begin n_err++; $display("FAIL mismatch errno: got %0d required %0d", oErrNo, exp_errno); end
        n_vec++;
        if (rd_q.size() != exp_rd_q.size()) begin n_err++; $display("FAIL mismatch rd_count: got %0d required %0d", rd_q.size(), exp_rd_q.size()); end
        for (int i = 0; i < exp_rd_q.size() && i < rd_q.size(); i++) begin
            n_vec++;
            if (rd_q[i] !== exp_rd_q[i]) begin n_err++; $display("FAIL mismatch rd[%0d]: got %h required %h", i, rd_q[i], exp_rd_q[i]); end
        end
    endtask

    task automatic test_rd_timeout();
        int ts, te, wait_cyc;
        bit b1;
        set_nominal_table();
        set_phy(0, 1'b0, 1'b0, 6, -1, 8'h00);
        run_seq(ts, te, b1);
        wait_cyc = te - last_ack_cyc;
        n_vec++;
        if ({oDone, oErr, oBusy} !== 3'b010) begin n_err++; $display("FAIL rd_timeout status: got done/err/busy=%b%b%b required 010", oDone, oErr, oBusy); end
        n_vec++;
        if (oErrNo !== 8'd6) begin n_err++; $display("FAIL rd_timeout errno: got %0d required 6", oErrNo); end
        n_vec++;
        if (wait_cyc < 256 || wait_cyc > 257) begin n_err++; $display("FAIL rd_timeout latency: got %0d cycles from ack required 256..257", wait_cyc); end
        n_vec++;
        if (rise_q.size() != 7 || oCmdReq !== 1'b0) begin n_err++; $display("FAIL rd_timeout req_quiet: got %0d requests req=%b required 7 and 0", rise_q.size(), oCmdReq); end
        n_vec++;
        if (rd_q.size() != exp_rd_q.size()) begin n_err++; $display("FAIL rd_timeout rd_count: got %0d required %0d", rd_q.size(), exp_rd_q.size()); end
    endtask

    task automatic test_reset_mid();
        int k, ts, te;
        bit b1;
        set_nominal_table();
        set_phy(5, 1'b0, 1'b0, -1, -1, 8'h00);
        @(negedge clk); iStart = 1'b1;
        @(negedge clk); iStart = 1'b0;
        k = 0;
        while (!(oCmdReq && oTblNo == 8'd2) && k < 2000) begin @(negedge clk); k++; end
        n_vec++;
        if (k >= 2000) begin n_err++; $display("FAIL reset_mid reach_idx2: got no index-2 request within %0d cycles", k); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({oTblNo, oCmdReq, oCmdWr, oCmdAddr, oCmdData, oRdStb, oRdAddr, oRdData, oBusy, oDone, oErr, oErrNo} !== 54'd0) begin
            n_err++;
            $display("FAIL reset_mid async_clear: got tbl=%h req=%b wr=%b addr=%h busy=%b, all required 0", oTblNo, oCmdReq, oCmdWr, oCmdAddr, oBusy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_phy(0, 1'b0, 1'b0, -1, -1, 8'h00);
        run_seq(ts, te, b1);
        n_vec++;
        if (rise_q.size() == 0 || rise_q[0] != ts + int'(P) + 1) begin
            n_err++;
            $display("FAIL reset_mid restart_first_req: got %0d required %0d", (rise_q.size() > 0) ? rise_q[0] : -1, ts + int'(P) + 1);
        end
        n_vec++;
        if (cmd_q.size() != exp_cmd_q.size() || (cmd_q.size() > 0 && cmd_q[0] !== exp_cmd_q[0])) begin
            n_err++;
            $display("FAIL reset_mid restart_cmds: got %0d cmds first %h required %0d first %h", cmd_q.size(), (cmd_q.size() > 0) ? cmd_q[0] : 17'h0, exp_cmd_q.size(), exp_cmd_q[0]);
        end
        n_vec++;
        if ({oDone, oErr} !== 2'b10) begin n_err++; $display("FAIL reset_mid status: got done/err=%b%b required 10", oDone, oErr); end
    endtask

    task automatic test_random();
        int ts, te, ci;
        bit b1;
        for (int r = 0; r < 8; r++) begin
            set_nominal_table();
            for (int i = 0; i < WRN; i++) tbl_data[i] = 8'($urandom);
            for (int i = 1; i < 4; i++) id_val[i] = 8'($urandom);
            ci = ($urandom_range(0, 2) == 0) ? int'($urandom_range(4, 9)) : -1;
            set_phy(0, 1'b1, 1'b0, -1, ci, 8'($urandom_range(1, 255)));
            run_seq(ts, te, b1);
            n_vec++;
            if ({oDone, oErr} !== {exp_done, exp_err} || (exp_err && oErrNo !== 8'(exp_errno))) begin
                n_err++;
                $display("FAIL random[%0d] status: got done/err/errno=%b%b/%0d required %b%b/%0d", r, oDone, oErr, oErrNo, exp_done, exp_err, exp_errno);
            end
            n_vec++;
            if (cmd_q.size() != exp_cmd_q.size()) begin n_err++; $display("FAIL random[%0d] cmd_count: got %0d required %0d", r, cmd_q.size(), exp_cmd_q.size()); end
            for (int i = 0; i < exp_cmd_q.size() && i < cmd_q.size(); i++) begin
                n_vec++;
                if (cmd_q[i] !== exp_cmd_q[i]) begin n_err++; $display("FAIL random[%0d] cmd[%0d]: got %h required %h", r, i, cmd_q[i], exp_cmd_q[i]); end
            end
            n_vec++;
            if (rd_q.size() != exp_rd_q.size()) begin n_err++; $display("FAIL random[%0d] rd_count: got %0d required %0d", r, rd_q.size(), exp_rd_q.size()); end
            for (int i = 0; i < exp_rd_q.size() && i < rd_q.size(); i++) begin
                n_vec++;
                if (rd_q[i] !== exp_rd_q[i]) begin n_err++; $display("FAIL random[%0d] rd[%0d]: got %h required %h", r, i, rd_q[i], exp_rd_q[i]); end
            end
        end
    endtask

    initial begin
        iStart = 1'b0;
        rst_n = 1'b0;
        set_nominal_table();
        set_phy(0, 1'b0, 1'b0, -1, -1, 8'h00);
        test_reset();
        test_nominal();
        test_ack_delay();
        test_mismatch();
        test_rd_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/octal_ram_init_seq.md
# octal_ram_init_seq

Power-up sequencer for the Octal PSRAM mode-register path. It waits out the device power-up time, then walks the mode-register configuration table by index. Table entries 0..WR_CNT-1 are issued as mode-register writes and entries WR_CNT..LAST_NO as mode-register reads. It captures each readback and reports done or error to the capture control logic, and holds the PSRAM command port until initialization completes.

## Interface
- PWRUP_CYCLES, 20000: clocks to wait after start before the first command (150 us at 133 MHz).
- WR_CNT, 4: number of leading table entries issued as writes.
- LAST_NO, 9: last table index issued; entries WR_CNT..LAST_NO are reads.
- TIMEOUT_CYCLES, 255: maximum clocks to wait for iCmdAck or iRdValid.

- iClk  in  1  system clock; all logic is on the rising edge.
- iRst_N  in  1  asynchronous active-low reset.
- iStart  in  1  single-cycle start pulse; accepted only in IDLE, DONE or ERR.
- oTblNo  out  8  index driven to the configuration table.
- iTblAddr  in  8  table register address; combinational from oTblNo.
- iTblData  in  8  table register data; combinational from oTblNo.
- oCmdReq  out  1  command request to the PSRAM PHY.
- oCmdWr  out  1  1 = mode-register write, 0 = mode-register read.
- oCmdAddr  out  8  mode-register address (MA).
- oCmdData  out  8  write data; 0 for reads.
- iCmdAck  in  1  PHY accepted the command this cycle.
- iRdValid  in  1  readback byte valid (single-cycle pulse).
- iRdData  in  8  readback byte.
- oRdStb  out  1  one-cycle strobe; oRdAddr/oRdData valid.
- oRdAddr  out  8  address of the captured readback.
- oRdData  out  8  captured readback.
- oBusy  out  1  sequence in progress.
- oDone  out  1  sequence completed without error; held until the next start.
- oErr  out  1  sequence aborted; held until the next start.
- oErrNo  out  8  table index at which the error occurred.

## Operation
- FSM states: IDLE, PWRUP, LOAD, ISSUE, WAIT_RD, NEXT, DONE, ERR.
- IDLE/DONE/ERR + iStart -> PWRUP:
  - clear oDone, oErr and oErrNo; set oBusy; oTblNo=0; load the power-up counter.
- PWRUP: count PWRUP_CYCLES clocks, then -> LOAD.
- LOAD: oTblNo has been stable for at least one cycle.
  - Register iTblAddr into oCmdAddr.
  - Writes (oTblNo<WR_CNT): oCmdWr=1, oCmdData=iTblData.
  - Reads: oCmdWr=0, oCmdData=0.
  - -> ISSUE.
- ISSUE: oCmdReq=1, with command fields held stable.
  - On iCmdAck: oCmdReq=0 the next cycle; a write -> NEXT, a read -> WAIT_RD.
  - If TIMEOUT_CYCLES elapse without iCmdAck -> ERR.
- WAIT_RD: on iRdValid, capture oRdAddr=oCmdAddr and oRdData=iRdData, pulse oRdStb, then compare (see Configuration) -> NEXT.
  - If TIMEOUT_CYCLES elapse without iRdValid -> ERR.
- NEXT: if oTblNo==LAST_NO -> DONE; otherwise oTblNo+1 -> LOAD.
- DONE: oDone=1, oBusy=0.
- ERR: oErr=1, oBusy=0, oErrNo=oTblNo at the point of failure, oCmdReq=0.
- iRdValid outside WAIT_RD is ignored. iCmdAck outside ISSUE is ignored.
- Write shadow: each write stores its data per address in slots for MA 0x00, 0x04, 0x06 and 0x08. Slots are cleared on start.
- Reset mid-operation returns to IDLE immediately; a request in flight is dropped, with no completion handshake.

## Timing
- Reset values: oTblNo=0, oCmdReq=0, oCmdWr=0, oCmdAddr=0, oCmdData=0, oRdStb=0, oRdAddr=0, oRdData=0, oBusy=0, oDone=0, oErr=0, oErrNo=0.
- All outputs are registered.
- iStart at cycle T: oBusy=1 at T+1.
- Power-up wait: first oCmdReq at T+1+PWRUP_CYCLES+1.
- Command handshake: iCmdAck sampled high while oCmdReq=1 completes the command; oCmdReq is low in the following cycle. Back-to-back commands have at least 2 idle cycles between them (NEXT, LOAD).
- Readback: iRdValid at cycle R gives oRdStb at R+1; oErr on a mismatch is also set at R+1.
- Timeout counters are 8-bit, reload on entering ISSUE or WAIT_RD, and expire at count TIMEOUT_CYCLES.
- iStart while busy is ignored.

## Configuration
- Macro OCTAL_RAM_RDBACK_CHK_EN.
- Defined: a readback whose address has a valid write-shadow slot is compared against the shadow byte (full 8 bits). A mismatch -> ERR with oErrNo = the read index. Reads of addresses never written (ID registers MA 0x01..0x03) are captured only.
- Undefined: no compare logic and no shadow registers are built. ERR is reachable only by timeout.

## Test plan
- Nominal run with PWRUP_CYCLES=10 and an immediate-ack PHY model that echoes written MRs:
  - 4 writes occur in order: (00,28), (04,40), (06,F0), (08,0F).
  - 6 reads occur at 00, 01, 02, 03, 04, 08.
  - oDone=1 and oErr=0.
- Ack delayed 5 cycles: oCmdReq is held 6 cycles with stable fields, and the sequence completes.
- With CHK_EN, the model returns 0x20 for MA 0x00: oErr=1, oErrNo=4, oDone=0. Without CHK_EN the same stimulus gives oDone=1.
- iRdValid never returned on index 6: oErr=1 and oErrNo=6 after 255 cycles; oCmdReq stays 0.
- iRst_N low during index 2 ISSUE: all outputs reach reset values asynchronously. A later iStart reruns the sequence from index 0 after the full power-up wait.
